// File: rtl/fg_prog_sequencer.sv
// ============================================================================
// Module   : fg_prog_sequencer
// Brief    : Floating-gate program sequencer: scan-in address, then
//            measure / inject until the target code or pulse limit is reached.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fg_prog_sequencer #(
    parameter int ISL_W      = 2,
    parameter int ROW_W      = 4,
    parameter int COL_W      = 4,
    parameter int CODE_W     = 10,
    parameter int PULSE_CYC  = 16,
    parameter int MAX_PULSES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ISL_W-1:0]  cmd_island,
    input  logic [ROW_W-1:0]  cmd_row,
    input  logic [COL_W-1:0]  cmd_col,
    input  logic [CODE_W-1:0] cmd_target,
    output logic              sel_sclk,
    output logic              sel_sdata,
    output logic              sel_latch,
    output logic              inj_en,
    output logic              meas_req,
    input  logic              meas_ack,
    input  logic [CODE_W-1:0] meas_code,
    output logic              done,
    output logic [1:0]        status
);

    localparam int c_AW   = ISL_W + ROW_W + COL_W;
    localparam int c_SC_W = $clog2(2 * c_AW);
    localparam int c_PC_W = $clog2(MAX_PULSES + 1);
    localparam int c_IC_W = $clog2(PULSE_CYC + 1);

    localparam logic [c_SC_W-1:0] c_SHIFT_LAST = c_SC_W'(2 * c_AW - 1);
    localparam logic [c_PC_W-1:0] c_PULSE_MAX  = c_PC_W'(MAX_PULSES);
    localparam logic [c_IC_W-1:0] c_INJ_LAST   = c_IC_W'(PULSE_CYC - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SHIFT = 3'd1;
    localparam logic [2:0] c_ST_LATCH = 3'd2;
    localparam logic [2:0] c_ST_MEAS  = 3'd3;
    localparam logic [2:0] c_ST_CMP   = 3'd4;
    localparam logic [2:0] c_ST_INJ   = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    logic [2:0]        r_state;
    logic [c_AW-1:0]   r_addr;
    logic [CODE_W-1:0] r_target;
    logic [CODE_W-1:0] r_code;
    logic [c_SC_W-1:0] r_shift_cnt;
    logic [c_PC_W-1:0] r_pulse_cnt;
    logic [c_IC_W-1:0] r_inj_cnt;
    logic [c_AW-1:0]   w_addr;

    assign w_addr = {cmd_island, cmd_row, cmd_col};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            cmd_ready   <= 1'b1;
            sel_sclk    <= 1'b0;
            sel_sdata   <= 1'b0;
            sel_latch   <= 1'b0;
            inj_en      <= 1'b0;
            meas_req    <= 1'b0;
            done        <= 1'b0;
            status      <= 2'b00;
            r_addr      <= '0;
            r_target    <= '0;
            r_code      <= '0;
            r_shift_cnt <= '0;
            r_pulse_cnt <= '0;
            r_inj_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= w_addr;
                        r_target    <= cmd_target;
                        r_pulse_cnt <= '0;
                        r_shift_cnt <= '0;
                        sel_sclk    <= 1'b0;
                        sel_sdata   <= w_addr[c_AW-1];
                        cmd_ready   <= 1'b0;
                        r_state     <= c_ST_SHIFT;
                    end
                end
                c_ST_SHIFT: begin
                    if (r_shift_cnt == c_SHIFT_LAST) begin
                        sel_sclk  <= 1'b0;
                        sel_sdata <= 1'b0;
                        sel_latch <= 1'b1;
                        r_state   <= c_ST_LATCH;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + 1'b1;
                        sel_sclk    <= ~sel_sclk;
                        // Advance to the next bit only after its high clock phase
                        if (sel_sclk) begin
                            r_addr    <= r_addr << 1;
                            sel_sdata <= r_addr[c_AW-2];
                        end
                    end
                end
                c_ST_LATCH: begin
                    sel_latch <= 1'b0;
                    meas_req  <= 1'b1;
                    r_state   <= c_ST_MEAS;
                end
                c_ST_MEAS: begin
                    if (meas_ack) begin
                        r_code   <= meas_code;
                        meas_req <= 1'b0;
                        r_state  <= c_ST_CMP;
                    end
                end
                c_ST_CMP: begin
                    if (r_code >= r_target) begin
                        done    <= 1'b1;
                        status  <= (r_pulse_cnt == '0) ? 2'b10 : 2'b00;
                        r_state <= c_ST_DONE;
                    end else if (r_pulse_cnt == c_PULSE_MAX) begin
                        done    <= 1'b1;
                        status  <= 2'b01;
                        r_state <= c_ST_DONE;
                    end else begin
                        inj_en    <= 1'b1;
                        r_inj_cnt <= '0;
                        r_state   <= c_ST_INJ;
                    end
                end
                c_ST_INJ: begin
                    if (r_inj_cnt == c_INJ_LAST) begin
                        inj_en      <= 1'b0;
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                        meas_req    <= 1'b1;
                        r_state     <= c_ST_MEAS;
                    end else begin
                        r_inj_cnt <= r_inj_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    sel_sclk  <= 1'b0;
                    sel_sdata <= 1'b0;
                    sel_latch <= 1'b0;
                    inj_en    <= 1'b0;
                    meas_req  <= 1'b0;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
